// File: rtl/dwa_element_selector_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dem_pkg
//  Purpose  : Shared sizing constants, types and helpers for the DWA dynamic
//             element matching stage.
//  Contents : CODE_WIDTH, NUM_ELEM, LFSR_SEED, LFSR_TAPS,
//             code_t, elem_vec_t, ptr_t, sum_t, mod_elem()
//  Revision : 1.0  initial release
// ============================================================================
package dem_pkg;

    localparam int CODE_WIDTH = 3;
    localparam int NUM_ELEM   = (2 ** CODE_WIDTH) - 1;
    localparam int SUM_WIDTH  = CODE_WIDTH + 2;

    typedef logic [CODE_WIDTH-1:0] code_t;
    typedef logic [NUM_ELEM-1:0]   elem_vec_t;
    typedef logic [CODE_WIDTH-1:0] ptr_t;
    typedef logic [SUM_WIDTH-1:0]  sum_t;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1: shift toward the MSB, and the
    // feedback bit is the XOR of bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam sum_t SUM_NUM_ELEM = sum_t'(NUM_ELEM);

    // Reduce ptr + code (+1) into 0..NUM_ELEM-1. The largest possible sum is
    // (NUM_ELEM-1) + NUM_ELEM + 1, so two conditional subtractions suffice.
    function automatic ptr_t mod_elem(input sum_t s);
        sum_t r;
        r = s;
        if (r >= SUM_NUM_ELEM) r = r - SUM_NUM_ELEM;
        if (r >= SUM_NUM_ELEM) r = r - SUM_NUM_ELEM;
        return ptr_t'(r);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwa_element_selector_if.sv
`default_nettype none
// ============================================================================
//  Module   : dwa_element_selector_if
//  Purpose  : Groups the quantizer-side input and the DAC-side outputs of the
//             DWA element selector.
//  Signals  : code_i     quantizer code (number of cells to turn on)
//             valid_i    code_i valid this cycle
//             elem_sel_o per-element enable vector
//             valid_o    elem_sel_o refreshed from a valid code
//             ptr_o      current rotation pointer
//  Modports : master (code source / output consumer), slave (selector)
//  Revision : 1.0  initial release
// ============================================================================
interface dwa_element_selector_if;
    import dem_pkg::*;

    code_t     code_i;
    logic      valid_i;
    elem_vec_t elem_sel_o;
    logic      valid_o;
    ptr_t      ptr_o;

    modport master (
        output code_i,
        output valid_i,
        input  elem_sel_o,
        input  valid_o,
        input  ptr_o
    );

    modport slave (
        input  code_i,
        input  valid_i,
        output elem_sel_o,
        output valid_o,
        output ptr_o
    );

endinterface
`default_nettype wire

// File: rtl/dwa_element_selector_thermo_rotate.sv
`default_nettype none
// ============================================================================
//  Module   : dwa_thermo_rotate
//  Purpose  : Combinational rotated thermometer encoder. Produces a NUM_ELEM
//             vector with code_i consecutive ones starting at element ptr_i,
//             wrapping from element NUM_ELEM-1 back to element 0.
//  Ports    : code_i  in  CODE_WIDTH  number of elements to enable
//             ptr_i   in  CODE_WIDTH  first element of the window
//             sel_o   out NUM_ELEM    rotated thermometer vector
//  Revision : 1.0  initial release
// ============================================================================
module dwa_thermo_rotate
    import dem_pkg::*;
(
    input  wire code_t     code_i,
    input  wire ptr_t      ptr_i,
    output elem_vec_t      sel_o
);

    // Element i is on when its distance ahead of the pointer (mod NUM_ELEM)
    // falls inside the window length. This is the thermometer of code_i
    // rotated left by ptr_i without building a double-width shifter.
    sum_t      offs;
    elem_vec_t sel_d;

    always_comb begin
        offs  = '0;
        sel_d = '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            offs = sum_t'(i) + SUM_NUM_ELEM - {2'b00, ptr_i};
            if (offs >= SUM_NUM_ELEM) begin
                offs = offs - SUM_NUM_ELEM;
            end
            sel_d[i] = (offs < {2'b00, code_i});
        end
    end

    assign sel_o = sel_d;

endmodule
`default_nettype wire

// File: rtl/dwa_element_selector.sv
`default_nettype none
// ============================================================================
//  Module   : dwa_element_selector
//  Purpose  : Data-weighted-averaging element selector. Each valid quantizer
//             code enables that many consecutive unit DAC cells starting at a
//             rotating pointer, so element mismatch is first-order shaped.
//             One clock of latency; no backpressure.
//  Ports    : clk_i  in  1   system clock, rising edge
//             rst_i  in  1   synchronous active-high reset
//             bus    slave   code_i/valid_i in, elem_sel_o/valid_o/ptr_o out
//  Config   : DWA_DITHER_EN - when defined, an 8-bit LFSR (seed 8'hA5) steps
//             on every valid code and, when its bit 0 is set, advances the
//             pointer one extra position after the selection is taken.
//  Revision : 1.0  initial release
// ============================================================================
module dwa_element_selector
    import dem_pkg::*;
(
    input  wire                     clk_i,
    input  wire                     rst_i,
    dwa_element_selector_if.slave   bus
);

    elem_vec_t elem_sel_q;
    elem_vec_t elem_sel_d;
    logic      valid_q;
    ptr_t      ptr_q;
    ptr_t      ptr_d;
    sum_t      ptr_sum;
    logic      dither_step;

    // Selection for the current sample always uses the current pointer;
    // any dither only affects where the next window starts.
    dwa_thermo_rotate u_thermo_rotate (
        .code_i (bus.code_i),
        .ptr_i  (ptr_q),
        .sel_o  (elem_sel_d)
    );

`ifdef DWA_DITHER_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    assign lfsr_d      = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    assign dither_step = lfsr_q[0];
`else
    assign dither_step = 1'b0;
`endif

    always_comb begin
        ptr_sum = {2'b00, ptr_q} + {2'b00, bus.code_i} + sum_t'(dither_step);
        ptr_d   = mod_elem(ptr_sum);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            elem_sel_q <= '0;
            valid_q    <= 1'b0;
            ptr_q      <= '0;
`ifdef DWA_DITHER_EN
            lfsr_q     <= LFSR_SEED;
`endif
        end else if (bus.valid_i) begin
            elem_sel_q <= elem_sel_d;
            valid_q    <= 1'b1;
            ptr_q      <= ptr_d;
`ifdef DWA_DITHER_EN
            lfsr_q     <= lfsr_d;
`endif
        end else begin
            // No new code: DAC keeps the last sample, pointer holds.
            valid_q    <= 1'b0;
        end
    end

    assign bus.elem_sel_o = elem_sel_q;
    assign bus.valid_o    = valid_q;
    assign bus.ptr_o      = ptr_q;

endmodule
`default_nettype wire
